// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NREQ byte requesters; tx_rdy one cycle after grant,
// ack/nak one cycle after the final tx_done or timeout; tx_busy holds the issue strobe off, error/timeout retries.
module uart_tx_arbiter #(
    parameter int NREQ      = 4,
    parameter int TIMEOUT   = 255,
    parameter int MAX_RETRY = 2
) (
    input  logic                clka,
    input  logic                reset,
    input  logic [NREQ-1:0]     req,
    input  logic [8*NREQ-1:0]   req_data,
    input  logic                tx_busy,
    input  logic                tx_done,
    input  logic                tx_error,
    output logic [NREQ-1:0]     gnt,
    output logic [NREQ-1:0]     ack,
    output logic [NREQ-1:0]     nak,
    output logic [7:0]          tx_data,
    output logic                tx_rdy,
    output logic [1:0]          arb_state,
    output logic                arb_idle
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [PW-1:0]   gidx_q, gidx_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [7:0]      data_q, data_d;
    logic [RW-1:0]   retry_q, retry_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic            ok_q, ok_d;

    logic            sel_vld;
    logic [PW-1:0]   sel_idx;
    logic [PW:0]     cand;
    logic [7:0]      sel_byte;
    logic            timeout_hit;

    // Scan from the highest offset down so the lowest offset from ptr wins.
    always_comb begin
        sel_vld = 1'b0;
        sel_idx = '0;
        cand    = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            cand = {1'b0, ptr_q} + (PW+1)'(i);
            if (cand >= (PW+1)'(NREQ)) begin
                cand = cand - (PW+1)'(NREQ);
            end
            if (req[cand[PW-1:0]]) begin
                sel_vld = 1'b1;
                sel_idx = cand[PW-1:0];
            end
        end
    end

    always_comb begin
        sel_byte = 8'h00;
        for (int i = 0; i < NREQ; i++) begin
            if (sel_idx == PW'(i)) begin
                sel_byte = req_data[8*i +: 8];
            end
        end
    end

    assign timeout_hit = (timer_q == TW'(TIMEOUT - 1));

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        gidx_d  = gidx_q;
        ptr_d   = ptr_q;
        data_d  = data_q;
        retry_d = retry_q;
        timer_d = timer_q;
        ok_d    = ok_q;
        tx_rdy  = 1'b0;
        ack     = '0;
        nak     = '0;
        case (state_q)
            IDLE: begin
                if (sel_vld) begin
                    gnt_d   = {{(NREQ-1){1'b0}}, 1'b1} << sel_idx;
                    gidx_d  = sel_idx;
                    data_d  = sel_byte;
                    retry_d = '0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                tx_rdy = ~tx_busy;
                if (!tx_busy) begin
                    timer_d = '0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                timer_d = timer_q + TW'(1);
                // A completing frame takes precedence over a coincident timeout.
                if (tx_done && !tx_error) begin
                    ok_d    = 1'b1;
                    state_d = RESP;
                end else if (tx_done || timeout_hit) begin
                    if (retry_q < RW'(MAX_RETRY)) begin
                        retry_d = retry_q + RW'(1);
                        state_d = ISSUE;
                    end else begin
                        ok_d    = 1'b0;
                        state_d = RESP;
                    end
                end
            end
            RESP: begin
                if (ok_q) begin
                    ack = gnt_q;
                end else begin
                    nak = gnt_q;
                end
                ptr_d   = (gidx_q == PW'(NREQ - 1)) ? '0 : gidx_q + PW'(1);
                gnt_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clka or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            gidx_q  <= '0;
            ptr_q   <= '0;
            data_q  <= 8'h00;
            retry_q <= '0;
            timer_q <= '0;
            ok_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            gidx_q  <= gidx_d;
            ptr_q   <= ptr_d;
            data_q  <= data_d;
            retry_q <= retry_d;
            timer_q <= timer_d;
            ok_q    <= ok_d;
        end
    end

    assign gnt       = gnt_q;
    assign tx_data   = data_q;
    assign arb_state = state_q;
    assign arb_idle  = (state_q == IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: fairness, single request, error retry, timeout exhaustion, busy hold, reset abort.
module tb_uart_tx_arbiter;

    localparam int NREQ      = 4;
    localparam int TIMEOUT   = 16;
    localparam int MAX_RETRY = 2;

    logic        clka     = 1'b0;
    logic        reset    = 1'b1;
    logic [3:0]  req      = '0;
    logic [31:0] req_data = '0;
    logic        tx_busy  = 1'b0;
    logic        tx_done  = 1'b0;
    logic        tx_error = 1'b0;
    logic [3:0]  gnt, ack, nak;
    logic [7:0]  tx_data;
    logic        tx_rdy;
    logic [1:0]  arb_state;
    logic        arb_idle;

    int errors  = 0;
    int checks  = 0;
    int rdy_cnt = 0;
    int consec  = 0;
    int ohv     = 0;
    logic prev_rdy = 1'b0;

    uart_tx_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT), .MAX_RETRY(MAX_RETRY)) dut (
        .clka(clka), .reset(reset), .req(req), .req_data(req_data),
        .tx_busy(tx_busy), .tx_done(tx_done), .tx_error(tx_error),
        .gnt(gnt), .ack(ack), .nak(nak), .tx_data(tx_data), .tx_rdy(tx_rdy),
        .arb_state(arb_state), .arb_idle(arb_idle)
    );

    always #5 clka = ~clka;

    // Mid-cycle monitor: strobe count, back-to-back strobes, grant one-hot / zero in IDLE.
    always @(negedge clka) begin
        if (tx_rdy) rdy_cnt++;
        if (tx_rdy && prev_rdy) consec++;
        if (!$onehot0(gnt) || (arb_idle && gnt != 4'b0)) ohv++;
        prev_rdy = tx_rdy;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clka);
        #1;
    endtask

    // Called in WAIT cycle 1; pulses tx_done in WAIT cycle 'delay'.
    task automatic finish_frame(input int delay, input logic err);
        repeat (delay - 1) tick();
        tx_done  = 1'b1;
        tx_error = err;
        tick();
        tx_done  = 1'b0;
        tx_error = 1'b0;
    endtask

    initial begin
        int order [4];
        logic [7:0] bytes [4];
        int r0;
        order = '{0, 1, 3, 0};
        bytes = '{8'hA0, 8'hB1, 8'hC2, 8'hD3};

        // Reset state
        tick();
        tick();
        reset = 1'b0;
        #1;
        chk("rst_gnt", gnt, 0);
        chk("rst_ack", ack, 0);
        chk("rst_nak", nak, 0);
        chk("rst_data", tx_data, 8'h00);
        chk("rst_rdy", tx_rdy, 0);
        chk("rst_state", arb_state, 0);
        chk("rst_idle", arb_idle, 1);

        // Idle ignores tx_done
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        chk("idle_done_ignored", arb_state, 0);

        // Fairness: 0, 1, 3; requester 0 re-requests during 1's response and is served after 3
        for (int i = 0; i < 4; i++) req_data[8*i +: 8] = bytes[i];
        req = 4'b1011;
        for (int k = 0; k < 4; k++) begin
            int e;
            e = order[k];
            tick();
            chk("fair_gnt", gnt, 32'(1) << e);
            chk("fair_data", tx_data, bytes[e]);
            tick();
            finish_frame(3, 1'b0);
            chk("fair_ack", ack, 32'(1) << e);
            req[e] = 1'b0;
            if (k == 1) req[0] = 1'b1;
            tick();
            chk("fair_idle", arb_idle, 1);
        end

        // Single request, tx_done 10 cycles into WAIT
        req_data[7:0] = 8'hA5;
        req = 4'b0001;
        r0 = rdy_cnt;
        tick();
        chk("single_state_issue", arb_state, 1);
        chk("single_gnt", gnt, 4'b0001);
        chk("single_data", tx_data, 8'hA5);
        chk("single_rdy", tx_rdy, 1);
        tick();
        chk("single_state_wait", arb_state, 2);
        chk("single_rdy_low", tx_rdy, 0);
        finish_frame(10, 1'b0);
        chk("single_state_resp", arb_state, 3);
        chk("single_ack", ack, 4'b0001);
        chk("single_nak", nak, 0);
        req = 4'b0000;
        tick();
        chk("single_back_idle", arb_state, 0);
        chk("single_ack_clear", ack, 0);
        chk("single_gnt_clear", gnt, 0);
        chk("single_rdy_pulses", rdy_cnt - r0, 1);

        // Error then success: two strobes with the same byte, then ack (ptr=1 so requester 2 wins)
        req_data[23:16] = 8'h5C;
        req = 4'b0100;
        r0 = rdy_cnt;
        tick();
        chk("retry_gnt", gnt, 4'b0100);
        chk("retry_data1", tx_data, 8'h5C);
        tick();
        finish_frame(2, 1'b1);
        chk("retry_reissue", arb_state, 1);
        chk("retry_rdy2", tx_rdy, 1);
        chk("retry_data2", tx_data, 8'h5C);
        chk("retry_no_nak", nak, 0);
        tick();
        finish_frame(4, 1'b0);
        chk("retry_ack", ack, 4'b0100);
        chk("retry_nak", nak, 0);
        req = 4'b0000;
        tick();
        chk("retry_rdy_pulses", rdy_cnt - r0, 2);

        // Timeout exhaustion: three attempts of 16 WAIT cycles each, then nak
        req_data[31:24] = 8'h3C;
        req = 4'b1000;
        r0 = rdy_cnt;
        tick();
        chk("to_gnt", gnt, 4'b1000);
        tick();
        for (int a = 0; a < 3; a++) begin
            repeat (TIMEOUT - 1) tick();
            chk("to_still_wait", arb_state, 2);
            chk("to_rdy_so_far", rdy_cnt - r0, a + 1);
            tick();
            if (a < 2) begin
                chk("to_reissue", arb_state, 1);
                chk("to_rdy", tx_rdy, 1);
                tick();
            end
        end
        chk("to_state_resp", arb_state, 3);
        chk("to_nak", nak, 4'b1000);
        chk("to_ack", ack, 0);
        req = 4'b0000;
        tick();
        chk("to_rdy_pulses", rdy_cnt - r0, 3);

        // Busy hold for 5 ISSUE cycles, stray tx_done in ISSUE, data change mid-WAIT (ptr=0 -> requester 1)
        req_data[15:8] = 8'hE7;
        req = 4'b0010;
        tx_busy = 1'b1;
        r0 = rdy_cnt;
        tick();
        chk("busy_gnt", gnt, 4'b0010);
        chk("busy_rdy_held", tx_rdy, 0);
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        repeat (3) tick();
        chk("busy_still_issue", arb_state, 1);
        chk("busy_no_rdy", rdy_cnt - r0, 0);
        tx_busy = 1'b0;
        #1;
        chk("busy_rdy_release", tx_rdy, 1);
        tick();
        chk("busy_wait", arb_state, 2);
        req_data[15:8] = 8'h18;
        finish_frame(5, 1'b0);
        chk("busy_data_stable", tx_data, 8'hE7);
        chk("busy_ack", ack, 4'b0010);
        req = 4'b0000;
        tick();
        chk("busy_rdy_pulses", rdy_cnt - r0, 1);

        // Reset mid-WAIT: ptr=2 so requester 3 is granted first; after reset requester 0 has priority
        req_data = {8'h33, 8'h22, 8'h11, 8'h44};
        req = 4'b1001;
        tick();
        chk("rw_gnt_before", gnt, 4'b1000);
        tick();
        tick();
        chk("rw_in_wait", arb_state, 2);
        reset = 1'b1;
        #1;
        chk("rw_gnt", gnt, 0);
        chk("rw_data", tx_data, 8'h00);
        chk("rw_state", arb_state, 0);
        chk("rw_idle", arb_idle, 1);
        chk("rw_ack", ack, 0);
        chk("rw_nak", nak, 0);
        tick();
        reset = 1'b0;
        tick();
        chk("rw_gnt_after", gnt, 4'b0001);
        chk("rw_data_after", tx_data, 8'h44);
        tick();
        finish_frame(1, 1'b0);
        chk("rw_ack_after", ack, 4'b0001);
        req = 4'b0000;
        tick();
        chk("rw_idle_after", arb_idle, 1);

        chk("rdy_never_consecutive", consec, 0);
        chk("gnt_onehot", ohv, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
